// File: rtl/program_counter_pkg.sv
// Shared constants for the Hack program counter and its word-level helpers.
package program_counter_pkg;

  // Native Hack machine word width.
  localparam int HACK_WORD = 16;

  // Value the counter takes on reset.
  localparam int PC_RESET_VALUE = 0;

  // Effective per-edge command, in priority order from lowest to highest.
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_LOAD  = 2'd2,
    PC_CLEAR = 2'd3
  } pc_cmd_e;

  // Resolve the three control lines into the command that wins on the edge.
  function automatic pc_cmd_e pc_decode(input logic reset, input logic load,
                                        input logic inc);
    pc_cmd_e cmd;
    cmd = PC_HOLD;
    if (reset)     cmd = PC_CLEAR;
    else if (load) cmd = PC_LOAD;
    else if (inc)  cmd = PC_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/program_counter_gates.sv
// Gate-cell library and the word-level blocks built from it: a 2:1 word mux
// and a ripple half-adder incrementer. Nand is the only primitive; every other
// cell is composed from it so the structure mirrors the gate chapter.

module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module not_gate (
  input  logic a,
  output logic y
);
  nand_gate u_nand (.a(a), .b(a), .y(y));
endmodule

module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n;
  nand_gate u_nand (.a(a), .b(b), .y(n));
  not_gate  u_not  (.a(n), .y(y));
endmodule

module or_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  logic na, nb;
  not_gate  u_na   (.a(a), .y(na));
  not_gate  u_nb   (.a(b), .y(nb));
  nand_gate u_nand (.a(na), .b(nb), .y(y));
endmodule

module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  // xor = (a | b) & ~(a & b)
  logic any, notboth;
  or_gate   u_or   (.a(a), .b(b), .y(any));
  nand_gate u_nand (.a(a), .b(b), .y(notboth));
  and_gate  u_and  (.a(any), .b(notboth), .y(y));
endmodule

module mux_bit (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  // sel=0 picks a, sel=1 picks b
  logic nsel, pa, pb;
  not_gate u_not (.a(sel), .y(nsel));
  and_gate u_pa  (.a(a), .b(nsel), .y(pa));
  and_gate u_pb  (.a(b), .b(sel), .y(pb));
  or_gate  u_or  (.a(pa), .b(pb), .y(y));
endmodule

module mux_word #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_bit u_mux (.a(a[i]), .b(b[i]), .sel(sel), .y(y[i]));
  end
endmodule

module inc_word #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  // Half-adder chain with the carry-in tied high. The top bit's carry-out is
  // the modulo-2^WIDTH overflow and is deliberately not generated.
  logic [WIDTH-1:0] carry;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    xor_gate u_sum (.a(a[i]), .b(carry[i]), .y(y[i]));
    if (i < WIDTH - 1) begin : g_carry
      and_gate u_cy (.a(a[i]), .b(carry[i]), .y(carry[i+1]));
    end
  end
endmodule

// File: rtl/program_counter.sv
// Hack program counter: clear / load / increment / hold, one edge latency.
// Next state comes from three cascaded word muxes (inc, then load, then reset)
// feeding an enabled register; out is the register itself.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int WIDTH = HACK_WORD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] RESET_WORD = WIDTH'(PC_RESET_VALUE);

  logic [WIDTH-1:0] pc_p0;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] sel_inc;
  logic [WIDTH-1:0] sel_load;
  logic [WIDTH-1:0] nxt;
  logic             any_cmd;
  logic             load_or_inc;

  inc_word #(.WIDTH(WIDTH)) u_inc (
    .a (pc_p0),
    .y (inc_val)
  );

  mux_word #(.WIDTH(WIDTH)) u_mux_inc (
    .a   (pc_p0),
    .b   (inc_val),
    .sel (inc),
    .y   (sel_inc)
  );

  mux_word #(.WIDTH(WIDTH)) u_mux_load (
    .a   (sel_inc),
    .b   (in),
    .sel (load),
    .y   (sel_load)
  );

  mux_word #(.WIDTH(WIDTH)) u_mux_rst (
    .a   (sel_load),
    .b   (RESET_WORD),
    .sel (reset),
    .y   (nxt)
  );

  // Register enable: the state only moves when some command is asserted.
  or_gate u_en_li  (.a(load), .b(inc), .y(load_or_inc));
  or_gate u_en_all (.a(reset), .b(load_or_inc), .y(any_cmd));

  // State register: synchronous clear, otherwise take the muxed next value when enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0 <= RESET_WORD;
    end else if (any_cmd) begin
      pc_p0 <= nxt;
    end
  end

  // ---- stage p0 boundary: out is the registered counter ----
  assign out = pc_p0;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: vector table, hand-written
// mid-cycle sequences and a random segment checked against a reference model.
module tb_program_counter;
  import program_counter_pkg::*;

  localparam int W = 16;

  logic         clock;
  logic         reset;
  logic         load;
  logic         inc;
  logic [W-1:0] in;
  logic [W-1:0] out;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  typedef struct {
    string        name;
    logic         reset;
    logic         load;
    logic         inc;
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  program_counter #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .inc   (inc),
    .in    (in),
    .out   (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: out=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic l,
                     input logic i, input logic [W-1:0] d,
                     input logic [W-1:0] e);
    vec_t v;
    v.name = nm; v.reset = r; v.load = l; v.inc = i; v.din = d; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one command, queue its expected result, then compare after the edge.
  task automatic step(input string nm, input logic r, input logic l,
                      input logic i, input logic [W-1:0] d,
                      input logic [W-1:0] e);
    logic [W-1:0] ex;
    string        en;
    reset = r; load = l; inc = i; in = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
    ex = exp_q.pop_front();
    en = name_q.pop_front();
    check(en, out, ex);
  endtask

  logic [W-1:0] model_pc;
  logic [W-1:0] held;
  logic         r_r, r_l, r_i;
  logic [W-1:0] r_d, r_e;

  initial begin
    reset = 1'b0; load = 1'b0; inc = 1'b0; in = '0;

    add("reset",         1, 0, 0, 16'h0000, 16'h0000);
    add("count1",        0, 0, 1, 16'h0000, 16'h0001);
    add("count2",        0, 0, 1, 16'h0000, 16'h0002);
    add("count3",        0, 0, 1, 16'h0000, 16'h0003);
    add("count4",        0, 0, 1, 16'h0000, 16'h0004);
    add("count5",        0, 0, 1, 16'h0000, 16'h0005);
    add("load_over_inc", 0, 1, 1, 16'h1234, 16'h1234);
    add("inc_after_ld",  0, 0, 1, 16'h0000, 16'h1235);
    add("load_ffff",     0, 1, 0, 16'hFFFF, 16'hFFFF);
    add("wrap0",         0, 0, 1, 16'h0000, 16'h0000);
    add("wrap1",         0, 0, 1, 16'h0000, 16'h0001);
    add("load_0042",     0, 1, 0, 16'h0042, 16'h0042);
    add("reset_dom",     1, 1, 1, 16'hBEEF, 16'h0000);
    add("load_0007",     0, 1, 0, 16'h0007, 16'h0007);
    add("hold_a",        0, 0, 0, 16'hAAAA, 16'h0007);
    add("hold_b",        0, 0, 0, 16'h5555, 16'h0007);
    add("hold_c",        0, 0, 0, 16'hFFFF, 16'h0007);
    add("hold_d",        0, 0, 0, 16'h0000, 16'h0007);
    add("inc_ign_in",    0, 0, 1, 16'hFFFF, 16'h0008);
    add("load_100",      0, 1, 0, 16'd100,  16'd100);
    add("cnt101",        0, 0, 1, 16'h0000, 16'd101);
    add("cnt102",        0, 0, 1, 16'h0000, 16'd102);
    add("cnt103",        0, 0, 1, 16'h0000, 16'd103);
    add("rst_midcount",  1, 0, 1, 16'h0000, 16'd0);
    add("resume1",       0, 0, 1, 16'h0000, 16'd1);
    add("resume2",       0, 0, 1, 16'h0000, 16'd2);

    foreach (vecs[k])
      step(vecs[k].name, vecs[k].reset, vecs[k].load, vecs[k].inc,
           vecs[k].din, vecs[k].exp);

    // Reset raised mid-cycle must not change out before the next edge.
    step("pre_0042", 0, 1, 0, 16'h0042, 16'h0042);
    #2;
    reset = 1'b1; load = 1'b1; inc = 1'b1; in = 16'hBEEF;
    #1;
    check("no_async_rst", out, 16'h0042);
    step("sync_rst", 1, 1, 1, 16'hBEEF, 16'h0000);

    // load/in changing mid-cycle must not leak through combinationally.
    step("pre_load", 0, 0, 1, 16'h0000, 16'h0001);
    held = out;
    #2;
    load = 1'b1; in = 16'hCAFE;
    #1;
    check("no_comb_load", out, held);
    in = 16'h1111;
    #1;
    check("no_comb_in", out, held);
    step("load_cafe", 0, 1, 0, 16'hCAFE, 16'hCAFE);

    // Random commands against an independent reference model.
    model_pc = 16'hCAFE;
    for (int n = 0; n < 60; n++) begin
      r_r = ($urandom_range(0, 9) == 0);
      r_l = ($urandom_range(0, 3) == 0);
      r_i = ($urandom_range(0, 1) == 1);
      r_d = W'($urandom);
      if (n % 15 == 7) begin
        r_l = 1'b1; r_r = 1'b0; r_d = 16'hFFFE;
      end
      case (pc_decode(r_r, r_l, r_i))
        PC_CLEAR: r_e = 16'h0000;
        PC_LOAD:  r_e = r_d;
        PC_INC:   r_e = model_pc + 16'h0001;
        default:  r_e = model_pc;
      endcase
      model_pc = r_e;
      step("random", r_r, r_l, r_i, r_d, r_e);
    end

    reset = 1'b0; load = 1'b0; inc = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
